// File: rtl/ahbl_split_seq_pkg.sv
// Shared AHB-Lite definitions for the width-splitting sequencer: HTRANS codes,
// FSM state encoding and bus-ratio helpers.
package ahbl_split_seq_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  // log2 of the bus width in bytes, i.e. the largest hsize the bus carries
  function automatic int bus_log2_bytes(input int w_bits);
    return $clog2(w_bits / 8);
  endfunction

  function automatic int bus_ratio(input int w_src, input int w_dst);
    return w_src / w_dst;
  endfunction

  function automatic int lane_bits(input int w_src, input int w_dst);
    return $clog2(w_src / w_dst);
  endfunction

endpackage

// File: rtl/ahbl_split_collate.sv
// Read collation: lane registers for early beats, final beat passed straight
// into its lane, replicated across all lanes for single-beat accesses.
module ahbl_split_collate
  import ahbl_split_seq_pkg::*;
#(
  parameter int W_SRC_DATA = 32,
  parameter int W_DST_DATA = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             capture,
  input  logic [lane_bits(W_SRC_DATA, W_DST_DATA)-1:0]     lane,
  input  logic                                             replicate,
  input  logic [W_DST_DATA-1:0]                            dst_hrdata,
  output logic [W_SRC_DATA-1:0]                            src_hrdata
);

  localparam int RATIO = bus_ratio(W_SRC_DATA, W_DST_DATA);
  localparam int LW    = lane_bits(W_SRC_DATA, W_DST_DATA);

  logic [W_DST_DATA-1:0] lane_r [RATIO];

  // Store completed non-final read beats in the lane their address selects
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RATIO; i++) begin
        lane_r[i] <= '0;
      end
    end else if (capture) begin
      lane_r[lane] <= dst_hrdata;
    end
  end

  // Merge stored lanes with the live final beat
  always_comb begin
    src_hrdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (replicate || (LW'(i) == lane)) begin
        src_hrdata[i*W_DST_DATA +: W_DST_DATA] = dst_hrdata;
      end else begin
        src_hrdata[i*W_DST_DATA +: W_DST_DATA] = lane_r[i];
      end
    end
  end

endmodule

// File: rtl/ahbl_split_seq.sv
// AHB-Lite bridge splitting one wide upstream access into N narrow NONSEQ beats.
// Optional AHBL_SPLIT_SEQ_ERR_ABORT_EN: a downstream error cancels unissued beats.
module ahbl_split_seq
  import ahbl_split_seq_pkg::*;
#(
  parameter int W_ADDR     = 32,
  parameter int W_SRC_DATA = 32,
  parameter int W_DST_DATA = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_hready,
  output logic                  src_hready_resp,
  output logic                  src_hresp,
  input  logic [W_ADDR-1:0]     src_haddr,
  input  logic                  src_hwrite,
  input  logic [1:0]            src_htrans,
  input  logic [2:0]            src_hsize,
  input  logic [W_SRC_DATA-1:0] src_hwdata,
  output logic [W_SRC_DATA-1:0] src_hrdata,
  output logic                  dst_hready,
  input  logic                  dst_hready_resp,
  input  logic                  dst_hresp,
  output logic [W_ADDR-1:0]     dst_haddr,
  output logic                  dst_hwrite,
  output logic [1:0]            dst_htrans,
  output logic [2:0]            dst_hsize,
  output logic [W_DST_DATA-1:0] dst_hwdata,
  input  logic [W_DST_DATA-1:0] dst_hrdata
);

  localparam int DMAX  = bus_log2_bytes(W_DST_DATA);
  localparam int SMAX  = bus_log2_bytes(W_SRC_DATA);
  localparam int RATIO = bus_ratio(W_SRC_DATA, W_DST_DATA);
  localparam int LW    = lane_bits(W_SRC_DATA, W_DST_DATA);

  state_t            state_r, state_s;
  logic [W_ADDR-1:0] base_r;
  logic              hwrite_r;
  logic [2:0]        hsize_r;
  logic [LW-1:0]     last_r, last_s, beat_r, addr_beat_s, lane_s;
  logic              err_r;
  logic              accept_s, is_last_s, beat_done_s, err_now_s;
  logic              abort_s, finish_s, fail_s, capture_s, replicate_s;
  logic              unused_s;

  assign unused_s    = src_htrans[0];
  assign accept_s    = (state_r == ST_IDLE) && src_hready && src_htrans[1];
  assign is_last_s   = (beat_r == last_r);
  assign beat_done_s = (state_r == ST_DATA) && dst_hready_resp;
  assign err_now_s   = err_r || dst_hresp;
`ifdef AHBL_SPLIT_SEQ_ERR_ABORT_EN
  assign abort_s     = (state_r == ST_DATA) && err_now_s;
`else
  assign abort_s     = 1'b0;
`endif
  assign finish_s    = beat_done_s && (is_last_s || abort_s);
  assign fail_s      = finish_s && err_now_s;

  // Beat count minus one; hsize beyond the upstream bus is clamped to it
  always_comb begin
    last_s = '0;
    if (src_hsize > 3'(DMAX)) begin
      if (src_hsize >= 3'(SMAX)) begin
        last_s = LW'(RATIO - 1);
      end else begin
        last_s = LW'((32'd1 << (src_hsize - 3'(DMAX))) - 32'd1);
      end
    end else begin
      last_s = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ADDR;
        else          state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (dst_hready_resp) state_s = ST_DATA;
        else                 state_s = ST_ADDR;
      end
      ST_DATA: begin
        if (finish_s) state_s = fail_s ? ST_ERR2 : ST_IDLE;
        else          state_s = ST_DATA;
      end
      ST_ERR2: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Access context; beat_r names the beat currently in its data phase
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      hwrite_r <= 1'b0;
      hsize_r  <= 3'd0;
      last_r   <= '0;
      beat_r   <= '0;
      err_r    <= 1'b0;
    end else if (accept_s) begin
      base_r   <= src_haddr;
      hwrite_r <= src_hwrite;
      hsize_r  <= src_hsize;
      last_r   <= last_s;
      beat_r   <= '0;
      err_r    <= 1'b0;
    end else if (state_r == ST_DATA) begin
      if (dst_hresp) err_r <= 1'b1;
      if (dst_hready_resp && !is_last_s) beat_r <= beat_r + LW'(1);
    end
  end

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
      end
      ST_ADDR: begin
        src_hready_resp = 1'b0;
        src_hresp       = 1'b0;
      end
      ST_DATA: begin
        src_hready_resp = finish_s && !fail_s;
        src_hresp       = fail_s;
      end
      ST_ERR2: begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b1;
      end
      default: begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
      end
    endcase
  end

  // Next address beat overlaps the current data beat; rst kills it at once
  always_comb begin
    dst_htrans = HTRANS_IDLE;
    if (rst) begin
      dst_htrans = HTRANS_IDLE;
    end else if (state_r == ST_ADDR) begin
      dst_htrans = HTRANS_NONSEQ;
    end else if ((state_r == ST_DATA) && !is_last_s && !abort_s) begin
      dst_htrans = HTRANS_NONSEQ;
    end else begin
      dst_htrans = HTRANS_IDLE;
    end
  end

  assign addr_beat_s = (state_r == ST_DATA) ? (beat_r + LW'(1)) : '0;
  assign dst_haddr   = base_r + (W_ADDR'(addr_beat_s) << DMAX);
  assign dst_hsize   = (hsize_r > 3'(DMAX)) ? 3'(DMAX) : hsize_r;
  assign dst_hwrite  = hwrite_r;
  assign dst_hready  = dst_hready_resp;
  // Data-phase lane: low bits of base plus beat index (beat stride is one lane)
  assign lane_s      = base_r[SMAX-1:DMAX] + beat_r;
  assign dst_hwdata  = src_hwdata[int'(lane_s)*W_DST_DATA +: W_DST_DATA];

  assign capture_s   = beat_done_s && !hwrite_r && !is_last_s;
  assign replicate_s = (last_r == '0);

  ahbl_split_collate #(
    .W_SRC_DATA (W_SRC_DATA),
    .W_DST_DATA (W_DST_DATA)
  ) u_collate (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture_s),
    .lane       (lane_s),
    .replicate  (replicate_s),
    .dst_hrdata (dst_hrdata),
    .src_hrdata (src_hrdata)
  );

endmodule

// File: tb/tb_ahbl_split_seq.sv
// Randomized bench for ahbl_split_seq: a downstream slave model with wait/error
// injection and a beat-level reference model of the expected upstream behaviour.
module tb_ahbl_split_seq;

  localparam int W_ADDR = 32;
  localparam int W_SRC  = 32;
  localparam int W_DST  = 16;
  localparam int DMAX   = $clog2(W_DST / 8);
`ifdef AHBL_SPLIT_SEQ_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              src_hready;
  logic              src_hready_resp;
  logic              src_hresp;
  logic [W_ADDR-1:0] src_haddr;
  logic              src_hwrite;
  logic [1:0]        src_htrans;
  logic [2:0]        src_hsize;
  logic [W_SRC-1:0]  src_hwdata;
  logic [W_SRC-1:0]  src_hrdata;
  logic              dst_hready;
  logic              dst_hready_resp;
  logic              dst_hresp;
  logic [W_ADDR-1:0] dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize;
  logic [W_DST-1:0]  dst_hwdata;
  logic [W_DST-1:0]  dst_hrdata;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ahbl_split_seq #(
    .W_ADDR     (W_ADDR),
    .W_SRC_DATA (W_SRC),
    .W_DST_DATA (W_DST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .src_hready      (src_hready),
    .src_hready_resp (src_hready_resp),
    .src_hresp       (src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (src_hrdata),
    .dst_hready      (dst_hready),
    .dst_hready_resp (dst_hready_resp),
    .dst_hresp       (dst_hresp),
    .dst_haddr       (dst_haddr),
    .dst_hwrite      (dst_hwrite),
    .dst_htrans      (dst_htrans),
    .dst_hsize       (dst_hsize),
    .dst_hwdata      (dst_hwdata),
    .dst_hrdata      (dst_hrdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One upstream access; err_beat/wait_beat outside 0..N-1 mean "none"
  task automatic run_access(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [15:0] rd0,
                            input logic [15:0] rd1, input int err_beat,
                            input int wait_beat, input int wait_n);
    int n, issued, end_c, n_acc, dp_k, dp_cyc, lane, low_cnt, last_c;
    bit err, dp_valid;
    logic [31:0] exp_rd;
    logic [15:0] rdk [2];
    rdk[0] = rd0;
    rdk[1] = rd1;
    n      = (int'(size) > DMAX) ? (1 << (int'(size) - DMAX)) : 1;
    err    = (err_beat < n);
    issued = (err && ABORT) ? err_beat + 1 : n;
    end_c  = 1;
    for (int k = 0; k < issued; k++)
      end_c += 1 + ((k == err_beat) ? 1 : ((k == wait_beat) ? wait_n : 0));
    last_c = err ? end_c + 1 : end_c;
    exp_rd = 32'h0;
    if (n == 1) begin
      exp_rd = {rd0, rd0};
    end else begin
      for (int k = 0; k < n; k++) begin
        lane = int'(((addr + 32'(2 * k)) >> 1) & 32'd1);
        exp_rd[lane*16 +: 16] = rdk[k];
      end
    end

    @(posedge clk); #1;
    src_htrans = 2'b10; src_haddr = addr; src_hwrite = wr; src_hsize = size;
    src_hwdata = $urandom;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = 16'($urandom);
    @(negedge clk);
    check_eq("idle_ready", src_hready_resp, 1);
    check_eq("idle_hresp", src_hresp, 0);
    check_eq("idle_htrans", dst_htrans, 0);

    n_acc = 0; dp_valid = 1'b0; dp_k = 0; dp_cyc = 0; low_cnt = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk); #1;
      src_htrans = 2'b00; src_haddr = $urandom; src_hwrite = 1'($urandom);
      src_hsize = 3'($urandom); src_hwdata = wdata;
      dst_hresp = 1'b0; dst_hready_resp = 1'b1; dst_hrdata = 16'($urandom);
      if (dp_valid) begin
        if (dp_k == err_beat) begin
          dst_hresp = 1'b1;
          dst_hready_resp = (dp_cyc != 0);
        end else if (dp_k == wait_beat && dp_cyc < wait_n) begin
          dst_hready_resp = 1'b0;
        end
        if (dst_hready_resp) dst_hrdata = (dp_k < 2) ? rdk[dp_k] : 16'hDEAD;
      end
      @(negedge clk);
      check_eq("dst_hready", dst_hready, dst_hready_resp);
      if (dp_valid && dst_hready_resp) begin
        if (wr && dp_k < n) begin
          lane = int'(((addr + 32'(2 * dp_k)) >> 1) & 32'd1);
          check_eq("hwdata", dst_hwdata, wdata[lane*16 +: 16]);
        end
        dp_valid = 1'b0;
      end else if (dp_valid) begin
        dp_cyc++;
      end
      if (dst_htrans != 2'b00 && dst_hready_resp) begin
        if (n_acc < issued) begin
          check_eq("haddr", dst_haddr, addr + 32'(2 * n_acc));
          check_eq("hsize", dst_hsize, (int'(size) > DMAX) ? DMAX : int'(size));
          check_eq("htrans", dst_htrans, 2'b10);
          check_eq("hwrite", dst_hwrite, wr);
        end
        dp_valid = 1'b1; dp_k = n_acc; dp_cyc = 0; n_acc++;
      end
      if (!src_hready_resp) low_cnt++;
      check_eq("src_ready", src_hready_resp, (!err && c == end_c) || (err && c == end_c + 1));
      check_eq("src_hresp", src_hresp, err && c >= end_c);
      if (!wr && !err && c == end_c) check_eq("rdata", src_hrdata, exp_rd);
    end
    check_eq("beats", n_acc, issued);
    check_eq("low_cycles", low_cnt, err ? end_c : end_c - 1);
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    src_htrans = 2'b10; src_haddr = 32'h600; src_hwrite = 1'b0; src_hsize = 3'd2;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0;
    @(posedge clk); #1;
    src_htrans = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_htrans", dst_htrans, 0);
    check_eq("rst_mid_ready", src_hready_resp, 1);
    check_eq("rst_mid_hresp", src_hresp, 0);
    @(negedge clk);
    check_eq("rst_mid_htrans2", dst_htrans, 0);
  endtask

  initial begin
    logic [2:0]  size;
    logic [31:0] addr;
    int          n, eb;
    rst = 1'b1; src_hready = 1'b1; src_haddr = 32'h0; src_hwrite = 1'b0;
    src_htrans = 2'b00; src_hsize = 3'd0; src_hwdata = 32'h0;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", src_hready_resp, 1);
    check_eq("reset_hresp", src_hresp, 0);
    check_eq("reset_htrans", dst_htrans, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_access(1'b0, 3'd2, 32'h100, 32'h0, 16'h1111, 16'h2222, 99, 99, 0);
    run_access(1'b1, 3'd2, 32'h200, 32'hCAFEBABE, 16'h0, 16'h0, 99, 99, 0);
    run_access(1'b0, 3'd0, 32'h303, 32'h0, 16'h5A3C, 16'h0, 99, 99, 0);
    run_access(1'b0, 3'd2, 32'h400, 32'h0, 16'h1234, 16'h5678, 0, 99, 0);
    run_access(1'b0, 3'd2, 32'h500, 32'h0, 16'hAAAA, 16'h5555, 99, 1, 3);
    run_access(1'b1, 3'd2, 32'h504, 32'h13579BDF, 16'h0, 16'h0, 99, 1, 3);
    run_access(1'b1, 3'd1, 32'h702, 32'hA1B2C3D4, 16'h0, 16'h0, 0, 99, 0);
    reset_mid();
    run_access(1'b0, 3'd2, 32'h800, 32'h0, 16'hBEEF, 16'hF00D, 99, 0, 2);

    for (int i = 0; i < 60; i++) begin
      size = 3'($urandom_range(0, 2));
      addr = {16'h0, 16'($urandom)} & ~((32'd1 << size) - 32'd1);
      n    = (int'(size) > DMAX) ? 2 : 1;
      eb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : 99;
      run_access(1'($urandom), size, addr, $urandom, 16'($urandom), 16'($urandom),
                 eb, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahbl_split_seq.md
AHBL_SPLIT_SEQ -- requirements
Module: ahbl_split_seq

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, address width.
REQ-002 SHALL have parameter W_SRC_DATA, default 32, upstream data width; power of 2.
REQ-003 SHALL have parameter W_DST_DATA, default 16, downstream data width; power of 2, strictly less than W_SRC_DATA.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have upstream slave ports:
- src_hready in 1
- src_hready_resp out 1
- src_hresp out 1
- src_haddr in W_ADDR
- src_hwrite in 1
- src_htrans in 2
- src_hsize in 3
- src_hwdata in W_SRC_DATA
- src_hrdata out W_SRC_DATA
REQ-006 SHALL have downstream master ports:
- dst_hready out 1
- dst_hready_resp in 1
- dst_hresp in 1
- dst_haddr out W_ADDR
- dst_hwrite out 1
- dst_htrans out 2
- dst_hsize out 3
- dst_hwdata out W_DST_DATA
- dst_hrdata in W_DST_DATA

Function
REQ-007 SHALL accept an upstream address phase when src_hready && src_htrans[1] in state IDLE, capturing haddr, hwrite and hsize.
REQ-008 SHALL compute DMAX = log2(W_DST_DATA/8) and the beat count N = 2^(hsize-DMAX) when hsize > DMAX, else N = 1.
REQ-009 SHALL use FSM states IDLE, ADDR, DATA and ERR2: IDLE -> ADDR on accept; ADDR -> DATA on dst_hready_resp; DATA -> DATA on pipelined next beat; DATA -> IDLE on last beat done; any -> ERR2 on error.
REQ-010 SHALL present beat k address phase (dst_htrans=NONSEQ, dst_hsize=min(hsize,DMAX), dst_haddr=base+k*W_DST_DATA/8) starting the cycle after accept; beat k+1 address SHALL overlap beat k data phase; no SEQ/burst.
REQ-011 SHALL drive dst_htrans=IDLE whenever no beat is pending.
REQ-012 SHALL drive dst_hready = dst_hready_resp.
REQ-013 SHALL drive dst_hwdata from the src_hwdata lane selected by the data-phase beat address bits [log2(W_SRC_DATA/8)-1:DMAX]; src_hwdata is held stable by the wait states.
REQ-014 SHALL register read beats 0..N-2 into lane-positioned collate registers and pass beat N-1 combinationally into its lane of src_hrdata.
REQ-015 SHALL replicate dst_hrdata across all lanes for N=1 accesses.
REQ-016 SHALL hold src_hready_resp low during the upstream data phase until the final dst data phase completes, then assert it in that same cycle.
REQ-017 Latency, zero-wait downstream: 32-bit access to 16-bit dst accepted at cycle 0 SHALL complete at cycle 3 (2 upstream wait states); an N=1 access SHALL complete at cycle 2.
REQ-018 SHALL return an upstream error on dst_hresp: cycle 1 src_hresp=1, src_hready_resp=0; cycle 2 (ERR2) src_hresp=1, src_hready_resp=1.
REQ-019 SHALL NOT accept a new upstream access until the current access, including any ERR2 cycle, has completed.
REQ-020 SHALL issue all dst beats to addresses inside the access's naturally aligned hsize window; unaligned input is undefined.

Reset
REQ-021 On rst SHALL enter IDLE with dst_htrans=IDLE, src_hready_resp=1, src_hresp=0 and collate registers=0.
REQ-022 Reset mid-access SHALL abandon the access immediately, with no further dst beats.

Configuration
REQ-023 With AHBL_SPLIT_SEQ_ERR_ABORT_EN defined, a dst error SHALL cancel all not-yet-issued beats (dst_htrans=IDLE) and an already-issued beat SHALL complete before the upstream error.
REQ-024 Without AHBL_SPLIT_SEQ_ERR_ABORT_EN, all N beats SHALL be issued, the error SHALL be latched, and the two-cycle error SHALL be reported after the last beat.

Structure
REQ-025 SHALL take HTRANS codes (IDLE=2'b00, NONSEQ=2'b10), the FSM state encodings and the DMAX/ratio constants from the shared AHB-Lite header.
REQ-026 SHALL place read collation (lane registers and final-beat mux) in one sub-module, ahbl_split_collate.

Verification
REQ-027 SHALL cover: 32-bit read of 0x100 with dst data 0x1111 then 0x2222 -> dst_haddr 0x100, 0x102; src_hrdata=0x22221111 at cycle 3.
REQ-028 SHALL cover: 32-bit write of 0xCAFEBABE to 0x200 -> dst_hwdata 0xBABE then 0xCAFE; src_hready_resp=1 at cycle 3.
REQ-029 SHALL cover: byte read of 0x303 -> one beat with dst_haddr 0x303, dst_hsize=0; src_hrdata has dst_hrdata replicated in both halves.
REQ-030 SHALL cover: 32-bit read with dst_hresp on beat 0 -> with the macro, beat 1 is never a new address phase and the 2-cycle error follows; without it, beat 1 is issued and the error follows.
REQ-031 SHALL cover: 32-bit access with dst_hready_resp low for 3 cycles on beat 1 -> src_hready_resp stays low 5 cycles; data is correct.
REQ-032 SHALL cover: rst asserted in cycle 2 of a 32-bit access -> next cycle dst_htrans=IDLE, src_hready_resp=1.
